// File: rtl/memory_access.sv
// memory_access: RV32I MEM stage with a req/ack data-memory port, branch resolution and the MEM/WB register.
// Accesses that see no ack for TIMEOUT cycles are abandoned and reported as bus errors.
module memory_access #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ALU_co_pype,
  input  logic [31:0] read_data2_pype2,
  input  logic [31:0] PCBranch_pype,
  input  logic [31:0] PCp4_pype2,
  input  logic [4:0]  WReg_pype2,
  input  logic        RegWrite_pype2,
  input  logic [1:0]  MemtoReg_pype2,
  input  logic [1:0]  MemRW_pype2,
  input  logic [2:0]  MemBranch_pype2,
  input  logic [31:0] Instraction_pype2,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall,
  output logic        branch_taken,
  output logic [31:0] branch_target,
  output logic        misalign,
  output logic        bus_err,
  output logic [31:0] mem_rdata_pype3,
  output logic [31:0] ALU_co_pype3,
  output logic [31:0] PCp4_pype3,
  output logic [4:0]  WReg_pype3,
  output logic        RegWrite_pype3,
  output logic [1:0]  MemtoReg_pype3
);
  localparam logic [7:0] TO = 8'(TIMEOUT);
  typedef enum logic [1:0] {IDLE, BUSY, ERR} state_t;
  state_t      state;
  logic [7:0]  cnt;
  logic [31:0] r_addr, r_wdata, c_addr, c_wdata, ld_data;
  logic [3:0]  r_be, c_be;
  logic [2:0]  r_f3, f3, eff_f3;
  logic [1:0]  r_lo, eff_lo;
  logic [15:0] lane;
  logic        r_we, c_we, memop, word, half, aligned, busy, issue, bubble, cond, is_load;
  always_comb begin
    f3 = Instraction_pype2[14:12];
    memop = MemRW_pype2 == 2'b01 || MemRW_pype2 == 2'b10;
    word = f3[1];
    half = !f3[1] && f3[0];
    aligned = word ? ALU_co_pype[1:0] == 2'b00 : !(half && ALU_co_pype[0]);
    c_we = MemRW_pype2 == 2'b10;
    c_addr = {ALU_co_pype[31:2], 2'b00};
    c_be = !c_we || word ? 4'b1111 : (half ? 4'b0011 : 4'b0001) << ALU_co_pype[1:0];
    c_wdata = word ? read_data2_pype2 : half ? {2{read_data2_pype2[15:0]}} : {4{read_data2_pype2[7:0]}};
    busy = state == BUSY;
    issue = rst && state == IDLE && memop && aligned;
    bubble = state == ERR || (state == IDLE && memop && !aligned);
    // the request fields are replayed from the issue-cycle snapshot while waiting
    dmem_req = issue || (rst && busy);
    dmem_we = busy ? r_we : c_we;
    dmem_addr = busy ? r_addr : c_addr;
    dmem_be = busy ? r_be : c_be;
    dmem_wdata = busy ? r_wdata : c_wdata;
    stall = dmem_req && !dmem_ack;
    is_load = busy ? !r_we : MemRW_pype2 == 2'b01;
    eff_lo = busy ? r_lo : ALU_co_pype[1:0];
    eff_f3 = busy ? r_f3 : f3;
    lane = 16'(dmem_rdata >> {eff_lo, 3'b000});
    ld_data = eff_f3[1] ? dmem_rdata :
              eff_f3[0] ? {{16{!eff_f3[2] && lane[15]}}, lane} :
                          {{24{!eff_f3[2] && lane[7]}}, lane[7:0]};
    cond = MemBranch_pype2 == 3'b001 ? ALU_co_pype == 32'd0 :
           MemBranch_pype2 == 3'b010 ? ALU_co_pype != 32'd0 :
           MemBranch_pype2 == 3'b011 ? ALU_co_pype == 32'd1 :
           MemBranch_pype2 == 3'b101 ? ALU_co_pype == 32'd0 :
           MemBranch_pype2 == 3'b100 || MemBranch_pype2 == 3'b110;
    branch_taken = rst && cond && !stall;
    branch_target = PCBranch_pype;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      {r_addr, r_wdata, r_be, r_we, r_lo, r_f3} <= '0;
      {misalign, bus_err} <= '0;
      {mem_rdata_pype3, ALU_co_pype3, PCp4_pype3, WReg_pype3, RegWrite_pype3, MemtoReg_pype3} <= '0;
    end else begin
      misalign <= state == IDLE && memop && !aligned;
      bus_err <= state == ERR;
      if (!stall) begin
        mem_rdata_pype3 <= bubble || !is_load ? '0 : ld_data;
        ALU_co_pype3 <= bubble ? '0 : ALU_co_pype;
        PCp4_pype3 <= bubble ? '0 : PCp4_pype2;
        WReg_pype3 <= bubble ? '0 : WReg_pype2;
        RegWrite_pype3 <= !bubble && RegWrite_pype2;
        MemtoReg_pype3 <= bubble ? '0 : MemtoReg_pype2;
      end
      if (issue && !dmem_ack) begin
        state <= TO == 8'd1 ? ERR : BUSY;
        cnt <= 8'd1;
        {r_addr, r_wdata, r_be, r_we, r_lo, r_f3} <= {c_addr, c_wdata, c_be, c_we, ALU_co_pype[1:0], f3};
      end else if (busy && dmem_ack) begin
        state <= IDLE;
        cnt <= '0;
      end else if (busy) begin
        state <= cnt + 8'd1 == TO ? ERR : BUSY;
        cnt <= cnt + 8'd1;
      end else if (state == ERR) begin
        state <= IDLE;
        cnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_memory_access.sv
// tb_memory_access: randomized instruction stream against a transaction-level model of the MEM stage.
module tb_memory_access;
  localparam int TO = 15;
  localparam int NEVER = 1000;
  logic        clk = 0;
  logic        rst;
  logic [31:0] ALU_co_pype, read_data2_pype2, PCBranch_pype, PCp4_pype2, Instraction_pype2;
  logic [4:0]  WReg_pype2;
  logic        RegWrite_pype2;
  logic [1:0]  MemtoReg_pype2, MemRW_pype2;
  logic [2:0]  MemBranch_pype2;
  logic        dmem_req, dmem_we, dmem_ack, stall, branch_taken, misalign, bus_err, RegWrite_pype3;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, branch_target, mem_rdata_pype3, ALU_co_pype3, PCp4_pype3;
  logic [3:0]  dmem_be;
  logic [4:0]  WReg_pype3;
  logic [1:0]  MemtoReg_pype3;
  always #5 clk = ~clk;
  memory_access #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .ALU_co_pype(ALU_co_pype), .read_data2_pype2(read_data2_pype2),
    .PCBranch_pype(PCBranch_pype), .PCp4_pype2(PCp4_pype2), .WReg_pype2(WReg_pype2),
    .RegWrite_pype2(RegWrite_pype2), .MemtoReg_pype2(MemtoReg_pype2), .MemRW_pype2(MemRW_pype2),
    .MemBranch_pype2(MemBranch_pype2), .Instraction_pype2(Instraction_pype2),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target), .misalign(misalign), .bus_err(bus_err),
    .mem_rdata_pype3(mem_rdata_pype3), .ALU_co_pype3(ALU_co_pype3), .PCp4_pype3(PCp4_pype3),
    .WReg_pype3(WReg_pype3), .RegWrite_pype3(RegWrite_pype3), .MemtoReg_pype3(MemtoReg_pype3)
  );
  int n_chk = 0, n_pass = 0;
  bit chk_en = 0;
  logic        exp_req, exp_we, exp_stall, exp_bt, exp_mis, exp_berr, exp_rw, cur_rw;
  logic [31:0] exp_addr, exp_wdata, exp_rd, exp_alu, exp_pc4;
  logic [3:0]  exp_be;
  logic [4:0]  exp_wreg;
  logic [1:0]  exp_m2r;
  int          obs_stalls;
  logic        obs_req, obs_we, obs_bt;
  logic [31:0] obs_addr, obs_wdata, obs_tgt;
  logic [3:0]  obs_be;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask
  function automatic int m_size(logic [2:0] f3);
    return f3[1] ? 4 : f3[0] ? 2 : 1;
  endfunction
  function automatic logic [3:0] m_be(logic [1:0] mrw, logic [2:0] f3, logic [1:0] lo);
    int n = m_size(f3);
    m_be = 4'hf;
    if (mrw == 2'b10)
      for (int i = 0; i < 4; i++) m_be[i] = i >= int'(lo) && i < int'(lo) + n;
  endfunction
  function automatic logic [31:0] m_wdata(logic [2:0] f3, logic [31:0] rs2);
    int n = m_size(f3);
    for (int i = 0; i < 4; i++) m_wdata[8*i +: 8] = rs2[8*(i % n) +: 8];
  endfunction
  function automatic logic [31:0] m_load(logic [2:0] f3, logic [1:0] lo, logic [31:0] w);
    logic [15:0] h = w[8*lo +: 16];
    logic [7:0]  b = w[8*lo +: 8];
    if (m_size(f3) == 4) return w;
    if (m_size(f3) == 2) return f3[2] ? 32'(h) : 32'($signed(h));
    return f3[2] ? 32'(b) : 32'($signed(b));
  endfunction
  function automatic bit m_cond(logic [2:0] mb, logic [31:0] a);
    case (mb)
      3'b001, 3'b101: return a == 0;
      3'b010:         return a != 0;
      3'b011:         return a == 1;
      3'b100, 3'b110: return 1;
      default:        return 0;
    endcase
  endfunction
  always @(negedge clk) if (chk_en) begin
    chk("dmem_req", dmem_req, exp_req);
    chk("stall", stall, exp_stall);
    chk("branch_taken", branch_taken, exp_bt);
    chk("branch_target", branch_target, PCBranch_pype);
    if (exp_req) begin
      chk("dmem_we", dmem_we, exp_we);
      chk("dmem_addr", dmem_addr, exp_addr);
      chk("dmem_be", dmem_be, exp_be);
      chk("dmem_wdata", dmem_wdata, exp_wdata);
    end
    chk("misalign", misalign, exp_mis);
    chk("bus_err", bus_err, exp_berr);
    chk("mem_rdata_pype3", mem_rdata_pype3, exp_rd);
    chk("ALU_co_pype3", ALU_co_pype3, exp_alu);
    chk("PCp4_pype3", PCp4_pype3, exp_pc4);
    chk("WReg_pype3", WReg_pype3, exp_wreg);
    chk("RegWrite_pype3", RegWrite_pype3, exp_rw);
    chk("MemtoReg_pype3", MemtoReg_pype3, exp_m2r);
  end
  task automatic clear_regs();
    {exp_mis, exp_berr, exp_rd, exp_alu, exp_pc4, exp_wreg, exp_rw, exp_m2r} = '0;
  endtask
  // one instruction, presented from just after a clock edge until the stage accepts it
  task automatic run(input logic [1:0] mrw, input logic [2:0] f3, input logic [31:0] alu, rs2, rdata,
                     input int d, input logic [2:0] mb, input logic [31:0] pcb, input int rst_at);
    logic [31:0] pc4 = $urandom, ins = $urandom;
    logic [4:0]  wreg = 5'($urandom);
    logic [1:0]  m2r = 2'($urandom);
    logic        rw = 1'($urandom);
    bit memop = mrw == 2'b01 || mrw == 2'b10;
    bit al = (int'(alu[1:0]) % m_size(f3)) == 0;
    bit reqs = memop && al;
    bit never = d >= TO;
    int last = !reqs ? 0 : never ? TO : d;
    cur_rw = rw;
    obs_stalls = 0;
    obs_req = 0;
    ins[14:12] = f3;
    for (int c = 0; c <= last; c++) begin
      {ALU_co_pype, read_data2_pype2, PCBranch_pype, PCp4_pype2, Instraction_pype2} = {alu, rs2, pcb, pc4, ins};
      {WReg_pype2, RegWrite_pype2, MemtoReg_pype2, MemRW_pype2, MemBranch_pype2} = {wreg, rw, m2r, mrw, mb};
      if (c == rst_at) begin
        rst = 0;
        dmem_ack = 0;
        {exp_req, exp_stall, exp_bt} = '0;
        @(posedge clk); #1;
        clear_regs();
        return;
      end
      rst = 1;
      dmem_ack = reqs && !never && c == d;
      dmem_rdata = dmem_ack ? rdata : $urandom;
      exp_req = reqs && (!never || c < TO);
      exp_stall = reqs && (never ? c < TO : c < d);
      exp_we = mrw == 2'b10;
      exp_addr = alu & 32'hFFFF_FFFC;
      exp_be = m_be(mrw, f3, alu[1:0]);
      exp_wdata = m_wdata(f3, rs2);
      exp_bt = m_cond(mb, alu) && !exp_stall;
      #2;
      if (stall) obs_stalls++;
      obs_req |= dmem_req;
      if (c == 0) {obs_we, obs_addr, obs_be, obs_wdata, obs_bt, obs_tgt} = {dmem_we, dmem_addr, dmem_be, dmem_wdata, branch_taken, branch_target};
      @(posedge clk); #1;
      exp_mis = 0;
      exp_berr = 0;
      if (c == last) begin
        if ((memop && !al) || (reqs && never)) begin
          clear_regs();
          exp_mis = memop && !al;
          exp_berr = reqs && never;
        end else begin
          exp_rd = mrw == 2'b01 ? m_load(f3, alu[1:0], rdata) : 32'd0;
          {exp_alu, exp_pc4, exp_wreg, exp_rw, exp_m2r} = {alu, pc4, wreg, rw, m2r};
        end
      end
    end
  endtask
  task automatic rnd();
    logic [1:0] mrw = 2'($urandom);
    logic [2:0] f3 = 3'($urandom);
    logic [31:0] alu = $urandom;
    int r = $urandom_range(0, 9);
    int d = r < 3 ? 0 : r < 8 ? r - 2 : r == 8 ? NEVER : TO - 1;
    bit memop = mrw == 2'b01 || mrw == 2'b10;
    logic [2:0] mb = memop ? 3'b000 : 3'($urandom);
    if ($urandom_range(0, 1) == 1) alu[1:0] = 2'b00;
    if (!memop) begin
      r = $urandom_range(0, 2);
      alu = r == 0 ? 32'd0 : r == 1 ? 32'd1 : alu;
    end
    run(mrw, f3, alu, $urandom, $urandom, d, mb, $urandom, $urandom_range(0, 39) == 0 ? $urandom_range(0, 4) : -1);
  endtask
  initial begin
    rst = 0;
    {ALU_co_pype, read_data2_pype2, PCBranch_pype, PCp4_pype2, Instraction_pype2, dmem_rdata} = '0;
    {WReg_pype2, RegWrite_pype2, MemtoReg_pype2, MemRW_pype2, MemBranch_pype2, dmem_ack} = '0;
    {exp_req, exp_stall, exp_bt, exp_we, exp_addr, exp_be, exp_wdata} = '0;
    clear_regs();
    @(posedge clk); #1;
    chk_en = 1;
    @(posedge clk); #1;
    chk("reset RegWrite_pype3", RegWrite_pype3, 0);
    chk("reset dmem_req", dmem_req, 0);
    run(2'b01, 3'b010, 32'h100, 0, 32'hDEADBEEF, 0, 3'b000, 0, -1);
    chk("LW stalls", obs_stalls, 0);
    chk("LW be", obs_be, 4'b1111);
    chk("LW data", mem_rdata_pype3, 32'hDEADBEEF);
    chk("LW regwrite", RegWrite_pype3, cur_rw);
    run(2'b01, 3'b000, 32'h103, 0, 32'h80112233, 3, 3'b000, 0, -1);
    chk("LB stalls", obs_stalls, 3);
    chk("LB data", mem_rdata_pype3, 32'hFFFFFF80);
    run(2'b01, 3'b100, 32'h103, 0, 32'h80112233, 3, 3'b000, 0, -1);
    chk("LBU data", mem_rdata_pype3, 32'h00000080);
    run(2'b10, 3'b001, 32'h202, 32'h0000ABCD, 0, 1, 3'b000, 0, -1);
    chk("SH we", obs_we, 1);
    chk("SH addr", obs_addr, 32'h200);
    chk("SH be", obs_be, 4'b1100);
    chk("SH wdata", obs_wdata, 32'hABCDABCD);
    chk("SH rdata3", mem_rdata_pype3, 0);
    run(2'b01, 3'b010, 32'h104, 0, 0, NEVER, 3'b000, 0, -1);
    chk("timeout stalls", obs_stalls, 15);
    chk("timeout bus_err", bus_err, 1);
    chk("timeout regwrite", RegWrite_pype3, 0);
    run(2'b01, 3'b010, 32'h102, 0, 0, 0, 3'b000, 0, -1);
    chk("misaligned req", obs_req, 0);
    chk("misaligned stalls", obs_stalls, 0);
    chk("misaligned pulse", misalign, 1);
    chk("misaligned regwrite", RegWrite_pype3, 0);
    run(2'b00, 3'b000, 32'h0, 0, 0, 0, 3'b001, 32'h40, -1);
    chk("BEQ taken", obs_bt, 1);
    chk("BEQ target", obs_tgt, 32'h40);
    run(2'b00, 3'b000, 32'h0, 0, 0, 0, 3'b010, 32'h40, -1);
    chk("BNE taken", obs_bt, 0);
    run(2'b01, 3'b010, 32'h108, 0, 0, NEVER, 3'b000, 0, 3);
    chk("reset-in-busy req", dmem_req, 0);
    chk("reset-in-busy ALU_co_pype3", ALU_co_pype3, 0);
    run(2'b01, 3'b010, 32'h10C, 0, 32'h12345678, 2, 3'b000, 0, -1);
    chk("after reset stalls", obs_stalls, 2);
    chk("after reset data", mem_rdata_pype3, 32'h12345678);
    for (int i = 0; i < 400; i++) rnd();
    @(negedge clk);
    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
